// File: rtl/loom_axil_mux.sv
// N-to-1 AXI-Lite multiplexer: independent round-robin read and write arbiters
// that hold each grant from address phase through response handshake.
module loom_axil_mux #(
  parameter int ADDR_WIDTH = 20,
  parameter int N_PORTS    = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  // upstream initiator ports
  input  logic [N_PORTS*ADDR_WIDTH-1:0] s_axil_araddr_i,
  input  logic [N_PORTS-1:0]            s_axil_arvalid_i,
  output logic [N_PORTS-1:0]            s_axil_arready_o,
  output logic [N_PORTS*32-1:0]         s_axil_rdata_o,
  output logic [N_PORTS*2-1:0]          s_axil_rresp_o,
  output logic [N_PORTS-1:0]            s_axil_rvalid_o,
  input  logic [N_PORTS-1:0]            s_axil_rready_i,
  input  logic [N_PORTS*ADDR_WIDTH-1:0] s_axil_awaddr_i,
  input  logic [N_PORTS-1:0]            s_axil_awvalid_i,
  output logic [N_PORTS-1:0]            s_axil_awready_o,
  input  logic [N_PORTS*32-1:0]         s_axil_wdata_i,
  input  logic [N_PORTS*4-1:0]          s_axil_wstrb_i,
  input  logic [N_PORTS-1:0]            s_axil_wvalid_i,
  output logic [N_PORTS-1:0]            s_axil_wready_o,
  output logic [N_PORTS*2-1:0]          s_axil_bresp_o,
  output logic [N_PORTS-1:0]            s_axil_bvalid_o,
  input  logic [N_PORTS-1:0]            s_axil_bready_i,
  // downstream initiator port
  output logic [ADDR_WIDTH-1:0]         m_axil_araddr_o,
  output logic                          m_axil_arvalid_o,
  input  logic                          m_axil_arready_i,
  input  logic [31:0]                   m_axil_rdata_i,
  input  logic [1:0]                    m_axil_rresp_i,
  input  logic                          m_axil_rvalid_i,
  output logic                          m_axil_rready_o,
  output logic [ADDR_WIDTH-1:0]         m_axil_awaddr_o,
  output logic                          m_axil_awvalid_o,
  input  logic                          m_axil_awready_i,
  output logic [31:0]                   m_axil_wdata_o,
  output logic [3:0]                    m_axil_wstrb_o,
  output logic                          m_axil_wvalid_o,
  input  logic                          m_axil_wready_i,
  input  logic [1:0]                    m_axil_bresp_i,
  input  logic                          m_axil_bvalid_i,
  output logic                          m_axil_bready_o
);

  localparam int GW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam logic [GW-1:0] LAST_RST = GW'(N_PORTS - 1);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} wr_state_e;

  rd_state_e       rd_state_q, rd_state_d;
  wr_state_e       wr_state_q, wr_state_d;
  logic [GW-1:0]   rd_grant_q, rd_grant_d, rd_last_q, rd_last_d;
  logic [GW-1:0]   wr_grant_q, wr_grant_d, wr_last_q, wr_last_d;
  logic            aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic            aw_hs, w_hs;

  // Round-robin pick: first requester strictly after the last winner, wrapping.
  function automatic logic [GW-1:0] rr_pick(input logic [N_PORTS-1:0] req,
                                            input logic [GW-1:0]      last);
    logic [GW-1:0] pick;
    logic          found;
    int            idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= N_PORTS; k++) begin
      idx = (int'(last) + k) % N_PORTS;
      if (!found && req[idx]) begin
        pick  = GW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Control state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_state_q <= R_IDLE;
      wr_state_q <= W_IDLE;
      rd_grant_q <= '0;
      wr_grant_q <= '0;
      rd_last_q  <= LAST_RST;
      wr_last_q  <= LAST_RST;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      wr_state_q <= wr_state_d;
      rd_grant_q <= rd_grant_d;
      wr_grant_q <= wr_grant_d;
      rd_last_q  <= rd_last_d;
      wr_last_q  <= wr_last_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

  // Read arbiter and channel routing
  always_comb begin
    rd_state_d       = rd_state_q;
    rd_grant_d       = rd_grant_q;
    rd_last_d        = rd_last_q;
    m_axil_arvalid_o = 1'b0;
    m_axil_rready_o  = 1'b0;
    s_axil_arready_o = '0;
    s_axil_rvalid_o  = '0;
    case (rd_state_q)
      R_IDLE: begin
        if (|s_axil_arvalid_i) begin
          rd_grant_d = rr_pick(s_axil_arvalid_i, rd_last_q);
          rd_state_d = R_ADDR;
        end
      end
      R_ADDR: begin
        m_axil_arvalid_o             = s_axil_arvalid_i[rd_grant_q];
        s_axil_arready_o[rd_grant_q] = m_axil_arready_i;
        if (m_axil_arvalid_o && m_axil_arready_i) rd_state_d = R_DATA;
      end
      R_DATA: begin
        s_axil_rvalid_o[rd_grant_q] = m_axil_rvalid_i;
        m_axil_rready_o             = s_axil_rready_i[rd_grant_q];
        if (m_axil_rvalid_i && m_axil_rready_o) begin
          rd_state_d = R_IDLE;
          rd_last_d  = rd_grant_q;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Write arbiter; AW and W are tracked separately so either may land first
  always_comb begin
    wr_state_d       = wr_state_q;
    wr_grant_d       = wr_grant_q;
    wr_last_d        = wr_last_q;
    aw_done_d        = aw_done_q;
    w_done_d         = w_done_q;
    aw_hs            = 1'b0;
    w_hs             = 1'b0;
    m_axil_awvalid_o = 1'b0;
    m_axil_wvalid_o  = 1'b0;
    m_axil_bready_o  = 1'b0;
    s_axil_awready_o = '0;
    s_axil_wready_o  = '0;
    s_axil_bvalid_o  = '0;
    case (wr_state_q)
      W_IDLE: begin
        if (|s_axil_awvalid_i) begin
          wr_grant_d = rr_pick(s_axil_awvalid_i, wr_last_q);
          wr_state_d = W_ADDR;
        end
      end
      W_ADDR: begin
        m_axil_awvalid_o             = s_axil_awvalid_i[wr_grant_q] & ~aw_done_q;
        m_axil_wvalid_o              = s_axil_wvalid_i[wr_grant_q] & ~w_done_q;
        s_axil_awready_o[wr_grant_q] = m_axil_awready_i & ~aw_done_q;
        s_axil_wready_o[wr_grant_q]  = m_axil_wready_i & ~w_done_q;
        aw_hs = m_axil_awvalid_o & m_axil_awready_i;
        w_hs  = m_axil_wvalid_o & m_axil_wready_i;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          wr_state_d = W_RESP;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
        end else begin
          aw_done_d = aw_done_q | aw_hs;
          w_done_d  = w_done_q | w_hs;
        end
      end
      W_RESP: begin
        s_axil_bvalid_o[wr_grant_q] = m_axil_bvalid_i;
        m_axil_bready_o             = s_axil_bready_i[wr_grant_q];
        if (m_axil_bvalid_i && m_axil_bready_o) begin
          wr_state_d = W_IDLE;
          wr_last_d  = wr_grant_q;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Payload follows the grant; responses are broadcast and qualified by valid
  assign m_axil_araddr_o = s_axil_araddr_i[int'(rd_grant_q)*ADDR_WIDTH +: ADDR_WIDTH];
  assign m_axil_awaddr_o = s_axil_awaddr_i[int'(wr_grant_q)*ADDR_WIDTH +: ADDR_WIDTH];
  assign m_axil_wdata_o  = s_axil_wdata_i[int'(wr_grant_q)*32 +: 32];
  assign m_axil_wstrb_o  = s_axil_wstrb_i[int'(wr_grant_q)*4 +: 4];
  assign s_axil_rdata_o  = {N_PORTS{m_axil_rdata_i}};
  assign s_axil_rresp_o  = {N_PORTS{m_axil_rresp_i}};
  assign s_axil_bresp_o  = {N_PORTS{m_axil_bresp_i}};

endmodule

// File: tb/tb_loom_axil_mux.sv
// Directed bench for loom_axil_mux with two upstream ports; the downstream
// target is driven by hand, cycle by cycle.
module tb_loom_axil_mux;
  localparam int AW = 20;
  localparam int NP = 2;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic [NP*AW-1:0] s_araddr, s_awaddr;
  logic [NP-1:0]    s_arvalid, s_arready, s_rvalid, s_rready;
  logic [NP-1:0]    s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [NP*32-1:0] s_rdata, s_wdata;
  logic [NP*4-1:0]  s_wstrb;
  logic [NP*2-1:0]  s_rresp, s_bresp;
  logic [AW-1:0]    m_araddr, m_awaddr;
  logic             m_arvalid, m_arready, m_rvalid, m_rready;
  logic             m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [31:0]      m_rdata, m_wdata;
  logic [3:0]       m_wstrb;
  logic [1:0]       m_rresp, m_bresp;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  loom_axil_mux #(.ADDR_WIDTH(AW), .N_PORTS(NP)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .s_axil_araddr_i(s_araddr), .s_axil_arvalid_i(s_arvalid), .s_axil_arready_o(s_arready),
    .s_axil_rdata_o(s_rdata), .s_axil_rresp_o(s_rresp), .s_axil_rvalid_o(s_rvalid),
    .s_axil_rready_i(s_rready),
    .s_axil_awaddr_i(s_awaddr), .s_axil_awvalid_i(s_awvalid), .s_axil_awready_o(s_awready),
    .s_axil_wdata_i(s_wdata), .s_axil_wstrb_i(s_wstrb), .s_axil_wvalid_i(s_wvalid),
    .s_axil_wready_o(s_wready), .s_axil_bresp_o(s_bresp), .s_axil_bvalid_o(s_bvalid),
    .s_axil_bready_i(s_bready),
    .m_axil_araddr_o(m_araddr), .m_axil_arvalid_o(m_arvalid), .m_axil_arready_i(m_arready),
    .m_axil_rdata_i(m_rdata), .m_axil_rresp_i(m_rresp), .m_axil_rvalid_i(m_rvalid),
    .m_axil_rready_o(m_rready),
    .m_axil_awaddr_o(m_awaddr), .m_axil_awvalid_o(m_awvalid), .m_axil_awready_i(m_awready),
    .m_axil_wdata_o(m_wdata), .m_axil_wstrb_o(m_wstrb), .m_axil_wvalid_o(m_wvalid),
    .m_axil_wready_i(m_wready), .m_axil_bresp_i(m_bresp), .m_axil_bvalid_i(m_bvalid),
    .m_axil_bready_o(m_bready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Entered at a negedge with arvalid already set and the read FSM idle.
  task automatic rd_txn(input string tag, input logic [1:0] exp_g, input logic [1:0] keep,
                        input logic [31:0] data, input logic [1:0] resp);
    @(negedge clk_i);
    m_arready = 1'b1;
    #1 check({tag, "_arvalid"}, m_arvalid, 1'b1);
    check({tag, "_arready"}, s_arready, exp_g);
    @(negedge clk_i);
    m_arready = 1'b0;
    s_arvalid = keep;
    m_rvalid  = 1'b1;
    m_rdata   = data;
    m_rresp   = resp;
    s_rready  = 2'b11;
    #1 check({tag, "_rvalid"}, s_rvalid, exp_g);
    check({tag, "_rdata"}, exp_g[1] ? s_rdata[63:32] : s_rdata[31:0], data);
    check({tag, "_rresp"}, exp_g[1] ? s_rresp[3:2] : s_rresp[1:0], resp);
    @(negedge clk_i);
    m_rvalid = 1'b0;
    #1 check({tag, "_rvalid_off"}, s_rvalid, 2'b00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0;
    s_araddr = '0; s_awaddr = '0; s_arvalid = '0; s_rready = '0;
    s_awvalid = '0; s_wvalid = '0; s_bready = '0; s_wdata = '0; s_wstrb = '0;
    m_arready = 0; m_rvalid = 0; m_rdata = '0; m_rresp = '0;
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = '0;

    // Reset: requests present but every handshake output held low
    s_arvalid = 2'b11; s_awvalid = 2'b11; m_arready = 1; m_rvalid = 1; m_bvalid = 1;
    repeat (2) @(negedge clk_i);
    #1 check("rst_m_arvalid", m_arvalid, 1'b0);
    check("rst_s_arready", s_arready, 2'b00);
    check("rst_s_rvalid", s_rvalid, 2'b00);
    check("rst_m_awvalid", m_awvalid, 1'b0);
    check("rst_s_bvalid", s_bvalid, 2'b00);
    check("rst_m_rready", m_rready, 1'b0);
    @(negedge clk_i);
    s_arvalid = '0; s_awvalid = '0; m_arready = 0; m_rvalid = 0; m_bvalid = 0;
    rst_ni = 1'b1;

    // Single read from port 1, one-cycle arbitration latency
    @(negedge clk_i);
    s_araddr[AW +: AW] = 20'h00040;
    s_arvalid = 2'b10;
    #1 check("p1rd_latency", m_arvalid, 1'b0);
    @(negedge clk_i);
    #1 check("p1rd_araddr", m_araddr, 20'h00040);
    check("p1rd_arvalid_pre", m_arvalid, 1'b1);
    #1;
    m_arready = 1'b1;
    #1 check("p1rd_arready", s_arready, 2'b10);
    @(negedge clk_i);
    m_arready = 0; s_arvalid = 2'b00;
    m_rvalid = 1; m_rdata = 32'h1234_5678; m_rresp = 2'b00; s_rready = 2'b10;
    #1 check("p1rd_rvalid", s_rvalid, 2'b10);
    check("p1rd_rdata", s_rdata[63:32], 32'h1234_5678);
    check("p1rd_rready", m_rready, 1'b1);
    @(negedge clk_i);
    m_rvalid = 0;
    #1 check("p1rd_idle", s_rvalid, 2'b00);

    // Contention: round-robin order 0,1,0,1
    s_arvalid = 2'b11;
    rd_txn("rr0", 2'b01, 2'b11, 32'h0000_0001, 2'b00);
    rd_txn("rr1", 2'b10, 2'b11, 32'h0000_0002, 2'b00);
    rd_txn("rr2", 2'b01, 2'b11, 32'h0000_0003, 2'b00);
    rd_txn("rr3", 2'b10, 2'b00, 32'h0000_0004, 2'b00);

    // Port 0 write: W presented early, W handshake before AW handshake
    @(negedge clk_i);
    s_wdata[31:0] = 32'hCAFE_BABE; s_wstrb[3:0] = 4'hF; s_wvalid = 2'b01;
    for (int i = 0; i < 3; i++) begin
      #1 check("wr_w_early", m_wvalid, 1'b0);
      @(negedge clk_i);
    end
    s_awaddr[AW-1:0] = 20'h00100; s_awvalid = 2'b01;
    #1 check("wr_idle_aw", m_awvalid, 1'b0);
    @(negedge clk_i);
    m_wready = 1'b1;
    #1 check("wr_wvalid", m_wvalid, 1'b1);
    check("wr_wdata", m_wdata, 32'hCAFE_BABE);
    check("wr_wstrb", m_wstrb, 4'hF);
    check("wr_wready", s_wready, 2'b01);
    check("wr_awready_hold", s_awready, 2'b00);
    @(negedge clk_i);
    m_wready = 1'b0; m_awready = 1'b1;
    #1 check("wr_w_done_mask", m_wvalid, 1'b0);
    check("wr_awvalid", m_awvalid, 1'b1);
    check("wr_awaddr", m_awaddr, 20'h00100);
    check("wr_awready", s_awready, 2'b01);
    @(negedge clk_i);
    s_awvalid = '0; s_wvalid = '0; m_awready = 0;
    m_bvalid = 1; m_bresp = 2'b00; s_bready = 2'b11;
    #1 check("wr_resp_awvalid", m_awvalid, 1'b0);
    check("wr_resp_wvalid", m_wvalid, 1'b0);
    check("wr_bvalid", s_bvalid, 2'b01);
    check("wr_bresp", s_bresp[1:0], 2'b00);
    check("wr_bready", m_bready, 1'b1);
    @(negedge clk_i);
    m_bvalid = 0;
    #1 check("wr_idle", s_bvalid, 2'b00);

    // Concurrent read (port 0) and write (port 1)
    @(negedge clk_i);
    s_araddr[AW-1:0] = 20'h00010; s_arvalid = 2'b01;
    s_awaddr[AW +: AW] = 20'h00200; s_awvalid = 2'b10;
    s_wdata[63:32] = 32'hA5A5_0F0F; s_wvalid = 2'b10;
    @(negedge clk_i);
    m_arready = 1; m_awready = 1; m_wready = 1;
    #1 check("cc_arready", s_arready, 2'b01);
    check("cc_awready", s_awready, 2'b10);
    check("cc_wready", s_wready, 2'b10);
    check("cc_wdata", m_wdata, 32'hA5A5_0F0F);
    check("cc_awaddr", m_awaddr, 20'h00200);
    @(negedge clk_i);
    s_arvalid = '0; s_awvalid = '0; s_wvalid = '0;
    m_arready = 0; m_awready = 0; m_wready = 0;
    m_rvalid = 1; m_bvalid = 1; m_bresp = 2'b11; s_rready = 2'b11; s_bready = 2'b11;
    #1 check("cc_rvalid", s_rvalid, 2'b01);
    check("cc_bvalid", s_bvalid, 2'b10);
    check("cc_bresp", s_bresp[3:2], 2'b11);
    @(negedge clk_i);
    m_rvalid = 0; m_bvalid = 0;
    #1 check("cc_idle", {s_rvalid, s_bvalid}, 4'b0000);

    // Grant on port 0 holds through a stalled AR and a dropped valid
    @(negedge clk_i);
    s_araddr[AW-1:0] = 20'h00ABC; s_araddr[AW +: AW] = 20'h00DEF; s_arvalid = 2'b01;
    @(negedge clk_i);
    for (int i = 0; i < 10; i++) begin
      s_arvalid = (i == 5) ? 2'b10 : 2'b11;
      #1 check("hold_arvalid", m_arvalid, (i == 5) ? 1'b0 : 1'b1);
      check("hold_araddr", m_araddr, 20'h00ABC);
      check("hold_arready", s_arready, 2'b00);
      @(negedge clk_i);
    end
    s_arvalid = 2'b11; m_arready = 1;
    #1 check("hold_release", s_arready, 2'b01);
    @(negedge clk_i);
    m_arready = 0; s_arvalid = 2'b10;
    m_rvalid = 1; m_rdata = 32'hDEAD_BEEF; m_rresp = 2'b10;
    #1 check("hold_rvalid", s_rvalid, 2'b01);
    check("hold_slverr", s_rresp[1:0], 2'b10);
    check("hold_bcast", s_rdata[63:32], 32'hDEAD_BEEF);
    @(negedge clk_i);
    m_rvalid = 0;
    #1 check("hold_idle", s_rvalid, 2'b00);
    rd_txn("hold_next", 2'b10, 2'b00, 32'h0000_0055, 2'b00);

    // Reset during R_DATA; arbitration restarts at port 0
    s_arvalid = 2'b01;
    rd_txn("pre_rst", 2'b01, 2'b00, 32'h0000_0066, 2'b00);
    s_arvalid = 2'b11;
    @(negedge clk_i);
    m_arready = 1;
    #1 check("pre_rst_grant", s_arready, 2'b10);
    @(negedge clk_i);
    s_arvalid = 2'b00; m_arready = 0; m_rvalid = 1; s_rready = 2'b11;
    #1 check("mid_rvalid", s_rvalid, 2'b10);
    #1 rst_ni = 1'b0;
    #1 check("rst_async_rvalid", s_rvalid, 2'b00);
    check("rst_async_rready", m_rready, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1 check("post_rst_rvalid", s_rvalid, 2'b00);
    @(negedge clk_i);
    #1 check("post_rst_noreplay", {s_rvalid, m_rready, m_arvalid}, 4'b0000);
    m_rvalid = 0;
    s_arvalid = 2'b11;
    rd_txn("post_rst", 2'b01, 2'b00, 32'h0000_0077, 2'b01);

    repeat (2) @(negedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/loom_axil_mux.md
LOOM_AXIL_MUX -- requirements
Module: loom_axil_mux

Interface
REQ-001 Parameter ADDR_WIDTH, default 20, address width of every AXI-Lite port.
REQ-002 Parameter N_PORTS, default 2, number of upstream AXI-Lite initiator ports (legal range 2..8).
REQ-003 clk_i  input  1  clock; rising edge.
REQ-004 rst_ni  input  1  reset; asynchronous, active-low.
REQ-005 s_axil_{ar,aw}addr_i  input  N_PORTS*ADDR_WIDTH  per-port addresses; port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-006 s_axil_{ar,aw,w}valid_i, s_axil_{r,b}ready_i  input  N_PORTS  per-port valids/readies.
REQ-007 s_axil_{ar,aw,w}ready_o, s_axil_{r,b}valid_o  output  N_PORTS  per-port readies/valids.
REQ-008 s_axil_wdata_i  input  N_PORTS*32; s_axil_wstrb_i  input  N_PORTS*4; per-port write data/strobes.
REQ-009 s_axil_rdata_o  output  N_PORTS*32; s_axil_rresp_o, s_axil_bresp_o  output  N_PORTS*2; per-port responses.
REQ-010 m_axil_*  single downstream AXI-Lite initiator port: araddr/awaddr ADDR_WIDTH, wdata 32, wstrb 4, rdata 32, rresp/bresp 2, each valid/ready 1; directions mirror a standard initiator.

Function
REQ-011 Read and write channels SHALL be arbitrated by two independent FSMs; a read and a write SHALL be allowed in flight simultaneously, from the same or different ports.
REQ-012 Read FSM states: R_IDLE, R_ADDR, R_DATA.
REQ-013 R_IDLE: when any s_axil_arvalid_i bit is set, latch the winner into rd_grant_q and enter R_ADDR next cycle; one cycle arbitration latency.
REQ-014 Winner = first requesting port searching upward from (rd_last_q+1) mod N_PORTS, wrapping (round-robin); rd_last_q resets to N_PORTS-1, so port 0 wins the first contention.
REQ-015 R_ADDR: m_axil_arvalid_o = s_axil_arvalid_i[g], m_axil_araddr_o = port g address unmodified, s_axil_arready_o[g] = m_axil_arready_i; on AR handshake enter R_DATA.
REQ-016 R_DATA: s_axil_rvalid_o[g] = m_axil_rvalid_i, m_axil_rready_o = s_axil_rready_i[g]; on R handshake return to R_IDLE and set rd_last_q = g.
REQ-017 Write FSM states: W_IDLE, W_ADDR, W_RESP; winner selection on any s_axil_awvalid_i bit, same round-robin rule with independent wr_last_q.
REQ-018 W_ADDR: forward AW and W of granted port independently; flags aw_done_q/w_done_q record each handshake; m_axil_awvalid_o = s_axil_awvalid_i[g] & ~aw_done_q, m_axil_wvalid_o = s_axil_wvalid_i[g] & ~w_done_q; W may precede, follow or coincide with AW.
REQ-019 When both AW and W handshakes have completed (including same cycle), enter W_RESP and clear flags.
REQ-020 W_RESP: s_axil_bvalid_o[g] = m_axil_bvalid_i, m_axil_bready_o = s_axil_bready_i[g]; on B handshake return to W_IDLE, set wr_last_q = g.
REQ-021 Non-granted ports, and all ports in IDLE, SHALL see every ready and valid output at 0; m_* valids/readies SHALL be 0 in IDLE.
REQ-022 s_axil_rdata_o/rresp_o/bresp_o SHALL broadcast m_axil_rdata_i/rresp_i/bresp_i to every port.
REQ-023 A grant SHALL be held until its response handshake completes; deasserting a granted valid before handshake (protocol violation) SHALL NOT change grant.
REQ-024 Responses (including SLVERR/DECERR) SHALL pass through unmodified; the block generates no responses itself.

Reset
REQ-025 On rst_ni low: both FSMs to IDLE, grants 0, rd_last_q/wr_last_q = N_PORTS-1, aw_done_q/w_done_q = 0, all valid/ready outputs 0, immediately and asynchronously.
REQ-026 Reset mid-transaction SHALL abandon it; no response is replayed after reset release.

Verification
REQ-027 Port 1 read 0x00040, others idle -> m_arvalid one cycle after s_arvalid[1]; rdata 0x1234_5678 returned only on s_rvalid[1].
REQ-028 Ports 0 and 1 assert arvalid same cycle from reset, repeat 4 times -> grant order 0,1,0,1.
REQ-029 Port 0 write with W valid 3 cycles before AW -> single m_aw and single m_w handshake, then W_RESP; bresp 2'b00 routed to port 0 only.
REQ-030 Port 0 read and port 1 write concurrent -> both complete, no cross-routing of rvalid/bvalid.
REQ-031 Downstream holds arready low 10 cycles while port 1 also requests -> grant stays on port 0 until its R handshake.
REQ-032 rst_ni pulsed during R_DATA -> all outputs 0 same cycle, next read arbitrates from port 0.
